// File: rtl/pipe_arb_pkg.sv
// Shared types and helpers for the message-granular round-robin arbiter.
package pipe_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Index width for an N-way selector, never narrower than one bit.
    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational N-way round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import pipe_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [2*N-1:0] dbl_s;
    int             j_s;

    // Rotate so ptr lands at bit 0; scanning downward leaves the lowest rotated bit as winner.
    always_comb begin
        dbl_s = {req, req} >> ptr;
        valid = 1'b0;
        idx   = {IDX_W{1'b0}};
        j_s   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (dbl_s[i]) begin
                valid = 1'b1;
                j_s   = int'(ptr) + i;
                if (j_s >= N) begin
                    j_s = j_s - N;
                end else begin
                    j_s = j_s;
                end
                idx = IDX_W'(j_s);
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/pipe_last_arbiter.sv
// Round-robin arbiter sharing one PipeInLast consumer among N producers, locked per message.
module pipe_last_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int width = 32,
    parameter int CNT_W = 16,
    localparam int IDX_W = idx_width(N)
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [N-1:0]       in_req,
    input  logic [N-1:0]       in_enq__ENA,
    input  logic [N*width-1:0] in_enq_v,
    input  logic [N-1:0]       in_enq_last,
    output logic [N-1:0]       in_enq__RDY,
    output logic               out_enq__ENA,
    output logic [width-1:0]   out_enq_v,
    output logic               out_enq_last,
    input  logic               out_enq__RDY,
    output logic               busy,
    output logic [IDX_W-1:0]   owner,
    output logic [CNT_W-1:0]   beat_cnt,
    output logic               err
);

    arb_state_e       state_r, state_nxt_s;
    logic [IDX_W-1:0] owner_r, owner_nxt_s;
    logic [IDX_W-1:0] rr_ptr_r, rr_ptr_nxt_s;
    logic [CNT_W-1:0] beat_cnt_r, beat_cnt_nxt_s;
    logic             err_r, err_nxt_s;
    logic             pick_valid_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic [N-1:0]     rdy_s;
    logic             own_ena_s, own_last_s, xfer_s;
    logic [width-1:0] own_v_s;

    rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
        .req   (in_req),
        .ptr   (rr_ptr_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Owner-selected beat mux and ready fan-out; only the owner ever sees ready.
    always_comb begin
        own_ena_s  = 1'b0;
        own_last_s = 1'b0;
        own_v_s    = {width{1'b0}};
        rdy_s      = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (owner_r == IDX_W'(i)) begin
                own_ena_s  = in_enq__ENA[i];
                own_last_s = in_enq_last[i];
                own_v_s    = in_enq_v[i*width +: width];
                rdy_s[i]   = (state_r == ARB_LOCKED) ? out_enq__RDY : 1'b0;
            end else begin
                rdy_s[i] = 1'b0;
            end
        end
    end

    // A beat only moves when the owner offers it and the consumer is ready.
    assign xfer_s        = (state_r == ARB_LOCKED) & own_ena_s & out_enq__RDY;
    assign in_enq__RDY   = rdy_s;
    assign out_enq__ENA  = xfer_s;
    assign out_enq_v     = xfer_s ? own_v_s : {width{1'b0}};
    assign out_enq_last  = xfer_s & own_last_s;
    assign busy          = (state_r == ARB_LOCKED);
    assign owner         = owner_r;
    assign beat_cnt      = beat_cnt_r;
    assign err           = err_r;

    // Next-state: grant in IDLE, count beats and release on last in LOCKED.
    always_comb begin
        state_nxt_s    = state_r;
        owner_nxt_s    = owner_r;
        rr_ptr_nxt_s   = rr_ptr_r;
        beat_cnt_nxt_s = beat_cnt_r;
        // Beats offered without ready are dropped and flagged until reset.
        err_nxt_s      = err_r | (|(in_enq__ENA & ~rdy_s));
        case (state_r)
            ARB_IDLE: begin
                if (pick_valid_s) begin
                    state_nxt_s    = ARB_LOCKED;
                    owner_nxt_s    = pick_idx_s;
                    beat_cnt_nxt_s = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_LOCKED: begin
                if (xfer_s) begin
                    if (beat_cnt_r != {CNT_W{1'b1}}) begin
                        beat_cnt_nxt_s = beat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        beat_cnt_nxt_s = beat_cnt_r;
                    end
                    if (own_last_s) begin
                        state_nxt_s = ARB_IDLE;
                        if (owner_r == IDX_W'(N - 1)) begin
                            rr_ptr_nxt_s = {IDX_W{1'b0}};
                        end else begin
                            rr_ptr_nxt_s = IDX_W'(int'(owner_r) + 1);
                        end
                    end else begin
                        state_nxt_s = ARB_LOCKED;
                    end
                end else begin
                    state_nxt_s = ARB_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // State and debug registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r    <= ARB_IDLE;
            owner_r    <= {IDX_W{1'b0}};
            rr_ptr_r   <= {IDX_W{1'b0}};
            beat_cnt_r <= {CNT_W{1'b0}};
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            owner_r    <= owner_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
            err_r      <= err_nxt_s;
        end
    end

endmodule

// File: tb/tb_pipe_last_arbiter.sv
// Self-checking bench for pipe_last_arbiter: vector table, directed corner sequences, random vs model.
module tb_pipe_last_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_d = 4'b0, ena_d = 4'b0, last_d = 4'b0;
    logic [127:0] v_d = 128'b0;
    logic         ordy_d = 1'b0;
    logic [3:0]   rdy_q;
    logic         oena_q, olast_q, busy_q, err_q;
    logic [31:0]  ov_q;
    logic [1:0]   owner_q;
    logic [15:0]  cnt_q;

    logic [31:0]  lane [4];
    int checks = 0, errors = 0;

    // Reference model: message-level arbiter state
    int   m_locked, m_owner, m_ptr, m_cnt, m_err;
    logic [3:0] m_rdy;

    pipe_last_arbiter #(.N(4), .width(32), .CNT_W(16)) dut (
        .CLK          (clk),
        .nRST         (rst_n),
        .in_req       (req_d),
        .in_enq__ENA  (ena_d),
        .in_enq_v     (v_d),
        .in_enq_last  (last_d),
        .in_enq__RDY  (rdy_q),
        .out_enq__ENA (oena_q),
        .out_enq_v    (ov_q),
        .out_enq_last (olast_q),
        .out_enq__RDY (ordy_d),
        .busy         (busy_q),
        .owner        (owner_q),
        .beat_cnt     (cnt_q),
        .err          (err_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_err = 0; m_rdy = 4'b0;
    endtask

    task automatic model_check();
        logic eo;
        m_rdy = (m_locked != 0) ? (4'(ordy_d) << m_owner) : 4'b0000;
        eo    = (m_locked != 0) && ena_d[m_owner] && ordy_d;
        chk("in_rdy", rdy_q, m_rdy);
        chk("out_ena", oena_q, eo);
        chk("out_v", ov_q, eo ? lane[m_owner] : 32'h0);
        chk("out_last", olast_q, eo ? last_d[m_owner] : 1'b0);
        chk("busy", busy_q, m_locked);
        chk("owner", owner_q, m_owner);
        chk("beat_cnt", cnt_q, m_cnt);
        chk("err", err_q, m_err);
    endtask

    task automatic model_step();
        int found;
        if ((ena_d & ~m_rdy) != 4'b0) m_err = 1;
        if (m_locked == 0) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (found == 0 && req_d[(m_ptr + k) % 4]) begin
                    found = 1; m_locked = 1; m_owner = (m_ptr + k) % 4; m_cnt = 0;
                end
            end
        end else if (ena_d[m_owner] && ordy_d) begin
            m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
            if (last_d[m_owner]) begin
                m_locked = 0;
                m_ptr = (m_owner + 1) % 4;
            end
        end
    endtask

    // Entered at posedge+1; compliant producers only raise ENA where ready is seen.
    task automatic drive(input logic [3:0] req, input logic [3:0] want, input logic [3:0] viol,
                         input logic [3:0] last, input logic [31:0] dat, input logic ordy);
        req_d = req; last_d = last; ordy_d = ordy;
        for (int i = 0; i < 4; i++) begin
            lane[i] = dat ^ (32'(i) << 16);
            v_d[i*32 +: 32] = lane[i];
        end
        #1;
        ena_d = (want & rdy_q) | viol;
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_d = 4'b0; ena_d = 4'b0; last_d = 4'b0; ordy_d = 1'b0;
        m_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  req, want, last;
        logic [31:0] dat;
        logic        ordy;
        logic        exp_busy;
        logic [1:0]  exp_owner;
        logic [3:0]  exp_rdy;
        logic        exp_oena;
        logic [31:0] exp_v;
        logic        exp_last;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl [5];
    int   k;
    logic [3:0] rl, rv;

    initial begin
        // Single requester 2, beats 0xA, 0xB, 0xC(last)
        tbl[0] = '{4'b0100, 4'b0000, 4'b0000, 32'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 32'h0,       1'b0, 16'd0};
        tbl[1] = '{4'b0100, 4'b0100, 4'b0000, 32'hA, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 32'h0002000A, 1'b0, 16'd0};
        tbl[2] = '{4'b0100, 4'b0100, 4'b0000, 32'hB, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 32'h0002000B, 1'b0, 16'd1};
        tbl[3] = '{4'b0100, 4'b0100, 4'b0100, 32'hC, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 32'h0002000C, 1'b1, 16'd2};
        tbl[4] = '{4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0, 32'h0,       1'b0, 16'd3};

        do_reset();
        for (int r = 0; r < 5; r++) begin
            drive(tbl[r].req, tbl[r].want, 4'b0, tbl[r].last, tbl[r].dat, tbl[r].ordy);
            chk("tbl_busy", busy_q, tbl[r].exp_busy);
            chk("tbl_owner", owner_q, tbl[r].exp_owner);
            chk("tbl_rdy", rdy_q, tbl[r].exp_rdy);
            chk("tbl_oena", oena_q, tbl[r].exp_oena);
            chk("tbl_v", ov_q, tbl[r].exp_v);
            chk("tbl_last", olast_q, tbl[r].exp_last);
            chk("tbl_cnt", cnt_q, tbl[r].exp_cnt);
            adv();
        end

        // Fairness: all requesting, single-beat messages, one grant every 2 cycles
        do_reset();
        k = 0;
        for (int c = 0; c < 10; c++) begin
            drive(4'hF, 4'hF, 4'h0, 4'hF, 32'h100 + 32'(c), 1'b1);
            if (oena_q) begin
                chk("fair_owner", owner_q, k % 4);
                chk("fair_cycle", c, 2 * k + 1);
                k++;
            end
            adv();
        end
        chk("fair_grants", k, 5);

        // Lock hold: owner 1 mid-message while requester 0 rises
        drive(4'b0010, 4'b0, 4'b0, 4'b0, 32'h0, 1'b1); adv();
        for (int b = 0; b < 2; b++) begin
            drive(4'b0011, 4'b0011, 4'b0, 4'b0, 32'h200 + 32'(b), 1'b1);
            chk("lock_rdy0", rdy_q[0], 1'b0);
            chk("lock_owner", owner_q, 2'd1);
            adv();
        end
        drive(4'b0011, 4'b0011, 4'b0, 4'b0010, 32'h2FF, 1'b1); adv();
        drive(4'b0101, 4'b0, 4'b0, 4'b0, 32'h0, 1'b1); adv();
        drive(4'b0101, 4'b0100, 4'b0, 4'b0100, 32'h300, 1'b1);
        chk("lock_next_owner", owner_q, 2'd2);
        chk("lock_next_ena", oena_q, 1'b1);
        adv();

        // Backpressure: consumer stalls 5 cycles mid-message
        drive(4'b0100, 4'b0, 4'b0, 4'b0, 32'h0, 1'b1); adv();
        drive(4'b0100, 4'b0100, 4'b0, 4'b0, 32'h400, 1'b1); adv();
        for (int s = 0; s < 5; s++) begin
            drive(4'b0100, 4'b0100, 4'b0, 4'b0, 32'h410, 1'b0);
            chk("bp_rdy", rdy_q[2], 1'b0);
            chk("bp_ena", oena_q, 1'b0);
            chk("bp_cnt", cnt_q, 16'd1);
            chk("bp_busy", busy_q, 1'b1);
            adv();
        end
        drive(4'b0100, 4'b0100, 4'b0, 4'b0100, 32'h420, 1'b1);
        chk("bp_resume", oena_q, 1'b1);
        adv();

        // Protocol error: requester 3 pushes while owner 0 holds the port
        drive(4'b0001, 4'b0, 4'b0, 4'b0, 32'h0, 1'b1); adv();
        drive(4'b0001, 4'b0001, 4'b1000, 4'b0, 32'h500, 1'b1);
        chk("perr_pre", err_q, 1'b0);
        chk("perr_data", ov_q, 32'h500);
        adv();
        drive(4'b0001, 4'b0001, 4'b0, 4'b0001, 32'h501, 1'b1);
        chk("perr_set", err_q, 1'b1);
        chk("perr_owner_last", olast_q, 1'b1);
        adv();
        drive(4'b0, 4'b0, 4'b0, 4'b0, 32'h0, 1'b1);
        chk("perr_sticky", err_q, 1'b1);
        chk("perr_idle", busy_q, 1'b0);
        adv();

        // Asynchronous reset between clock edges while LOCKED
        drive(4'b0010, 4'b0, 4'b0, 4'b0, 32'h0, 1'b1); adv();
        drive(4'b0010, 4'b0010, 4'b0, 4'b0, 32'h600, 1'b1); adv();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy_q, 1'b0);
        chk("rst_owner", owner_q, 2'd0);
        chk("rst_cnt", cnt_q, 16'd0);
        chk("rst_err", err_q, 1'b0);
        chk("rst_rdy", rdy_q, 4'b0);
        chk("rst_oena", oena_q, 1'b0);
        chk("rst_ov", ov_q, 32'h0);
        req_d = 4'b0; ena_d = 4'b0; last_d = 4'b0;
        m_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(4'b1001, 4'b0, 4'b0, 4'b0, 32'h0, 1'b1); adv();
        drive(4'b1001, 4'b1001, 4'b0, 4'b1001, 32'h700, 1'b1);
        chk("rst_regrant", owner_q, 2'd0);
        adv();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            rl = 4'b0;
            for (int i = 0; i < 4; i++) rl[i] = ($urandom_range(0, 2) == 0);
            rv = ($urandom_range(0, 39) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
            drive(4'($urandom), 4'($urandom), rv, rl, $urandom, ($urandom_range(0, 4) != 0));
            adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_last_arbiter.md
# pipe_last_arbiter

Message-granular round-robin arbiter that lets N producers share one PipeInLast consumer port, such as the enq port fed toward the host by the simulation message pipes. A requester wins the port for a whole message: the grant is held from its first beat until the beat carrying enq$last transfers. The block also keeps per-message beat count and protocol-error status for debug.

## Interface
- N, 4: number of requesters, 2..16.
- width, 32: data width of enq$v.
- CNT_W, 16: width of the beat counter.

Ports:
- CLK  input  1  clock; all state on posedge.
- nRST  input  1  reset, asynchronous, active-low.
- in_req  input  N  requester i has a message pending; level, may be held across messages.
- in_enq__ENA  input  N  beat valid from requester i; legal only while in_enq__RDY[i]=1.
- in_enq$v  input  N*width  data, requester i in bits [i*width +: width].
- in_enq$last  input  N  final beat of the message.
- in_enq__RDY  output  N  ready to requester i.
- out_enq__ENA  output  1  beat to consumer.
- out_enq$v  output  width  data to consumer.
- out_enq$last  output  1  last flag to consumer.
- out_enq__RDY  input  1  consumer ready.
- busy  output  1  a message is in progress (state LOCKED).
- owner  output  clog2(N) (min 1)  current or most recent grant holder.
- beat_cnt  output  CNT_W  beats transferred in the current message; saturates at all-ones.
- err  output  1  sticky protocol error.

## Operation
- States: IDLE, LOCKED(owner).
- IDLE: all in_enq__RDY=0; out_enq__ENA=0. If any in_req is set, pick the first set bit at or after rr_ptr, wrapping modulo N. Register owner, clear beat_cnt, go LOCKED next cycle. If no in_req is set, stay IDLE.
- LOCKED:
  - in_enq__RDY[owner]=out_enq__RDY; all other RDY bits are 0.
  - out_enq__ENA=in_enq__ENA[owner]; out_enq$v and out_enq$last are muxed from owner.
  - Each transferred beat (out_enq__ENA=1) increments beat_cnt, saturating.
  - A beat with last=1 sets rr_ptr to (owner+1) mod N and moves to IDLE.
  - in_req changes during LOCKED are ignored; the lock holds until the last beat.
- Single-beat message (last on the first beat): LOCKED lasts exactly one transfer cycle.
- err is set when in_enq__ENA[i]=1 while in_enq__RDY[i]=0, for any i. That beat is dropped and not forwarded. err clears only on reset.
- out_enq$v and out_enq$last are 0 whenever out_enq__ENA=0. This keeps the output free of X and matches the sources, which zero idle outputs.

## Timing
- Arbitration costs 1 cycle. in_req sampled in IDLE at edge k means LOCKED at k+1, and the first beat can pass in cycle k+1.
- Data path is combinational from owner to the consumer, with 0 cycles added latency.
- After the last beat there is 1 IDLE bubble cycle. Back-to-back messages therefore cost L+1 cycles each.
- Consumer stall (out_enq__RDY=0) holds LOCKED indefinitely, with no timeout.
- Reset values: state IDLE, owner 0, rr_ptr 0, beat_cnt 0, busy 0, err 0. All in_enq__RDY=0 and out_enq__ENA=0. Reset asserted mid-message aborts it; the consumer sees a truncated message with no last.
- Fairness: with all N requesting continuously, grants rotate 0,1,…,N-1,0.

## Structure
- Shared package pipe_arb_pkg holds the state enum (ARB_IDLE, ARB_LOCKED) and the clog2-based index-width function.
- One sub-module, rr_pick: a combinational N-way round-robin picker. Inputs are req and ptr; outputs are a valid flag and the picked index. The top level holds the FSM, the counters and the muxes.
- The flattened port list (no interface type at the top) keeps the N-wide arrays parameterizable. A wrapper that binds PipeInLast instances is out of scope.

## Test plan
- Single requester: req[2]=1, message of 3 beats 0xA,0xB,0xC(last). Consumer sees the same 3 beats in order; owner=2; beat_cnt reaches 3; IDLE on the cycle after 0xC.
- All 4 requesting continuously, 1-beat messages: grant order 0,1,2,3,0, one message every 2 cycles.
- Lock hold: owner 1 is mid-message and req[0] rises. No beat from 0 passes until owner 1 sends last, and the next grant is 2 if requesting, else 3, else 0.
- Backpressure: out_enq__RDY=0 for 5 cycles mid-message. in_enq__RDY[owner]=0 throughout, no beats move, beat_cnt is unchanged, state stays LOCKED.
- Protocol error: in_enq__ENA[3]=1 while owner=0. err=1 sticky, the beat does not appear at the output, and owner 0's message completes normally.
- Reset mid-message: drop nRST asynchronously between clock edges. All outputs go to reset values immediately, without waiting for a clock edge; after release, the arbiter grants from rr_ptr=0.
